// File: rtl/wb_mem_slave.sv
// wb_mem_slave: pipelined Wishbone memory slave, fixed RD_LAT response latency, bounded outstanding requests.
// Define WB_MEM_SLAVE_ADDR_ERR_EN to answer out-of-range addresses with wb_err_o instead of wrapping.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

module wb_mem_slave #(
   parameter int MEM_WORDS = 1024,
   parameter int RD_LAT    = 2,
   parameter int MAX_OUTST = 4
) (
   input  logic                        wb_clk_i,
   input  logic                        rst_n,
   input  logic                        wb_cyc_i,
   input  logic                        wb_stb_i,
   input  logic                        wb_we_i,
   input  logic [`CORE_ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [`CORE_DATA_WIDTH-1:0] wb_dat_i,
   input  logic [`CORE_BE_WIDTH-1:0]   wb_sel_i,
   output logic [`CORE_DATA_WIDTH-1:0] wb_dat_o,
   output logic                        wb_ack_o,
   output logic                        wb_stall_o,
   output logic                        wb_err_o
);
   localparam int AW = `CORE_ADDR_WIDTH;
   localparam int DW = `CORE_DATA_WIDTH;
   localparam int BW = `CORE_BE_WIDTH;
   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(MAX_OUTST + 1);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [RD_LAT-1:0] p_vld, p_rd, p_err;
   logic [DW-1:0]     p_dat [RD_LAT];
   logic [DW-1:0]     mem [MEM_WORDS];
   logic [IW-1:0]     idx;
   logic              acc, resp, flush, bad, unused_ok;

   assign idx = wb_adr_i[IW+1:2];
   assign resp = p_vld[RD_LAT-1] & wb_cyc_i & (state != ABORT);
   assign wb_stall_o = (state == ABORT) | ((cnt == CW'(MAX_OUTST)) & ~resp);
   assign acc = wb_cyc_i & wb_stb_i & ~wb_stall_o;
   // a dropped cycle with work in flight discards the pipeline on the same edge it enters ABORT
   assign flush = (state == ABORT) | ((state == BUSY) & ~wb_cyc_i & (cnt != '0));
   assign wb_dat_o = (wb_ack_o & p_rd[RD_LAT-1]) ? p_dat[RD_LAT-1] : '0;
   assign unused_ok = ^{wb_adr_i[1:0], wb_adr_i[AW-1:IW+2], p_err[RD_LAT-1]};

`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
   assign bad = {1'b0, wb_adr_i} >= (AW+1)'(MEM_WORDS * 4);
   assign wb_ack_o = resp & ~p_err[RD_LAT-1];
   assign wb_err_o = resp & p_err[RD_LAT-1];
`else
   assign bad = 1'b0;
   assign wb_ack_o = resp;
   assign wb_err_o = 1'b0;
`endif

   always_comb begin
      cnt_nxt = flush ? '0 : cnt + CW'(acc) - CW'(resp);
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = acc ? BUSY : IDLE;
         BUSY:    state_nxt = (~wb_cyc_i & (cnt != '0)) ? ABORT : (cnt_nxt == '0) ? IDLE : BUSY;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         p_vld <= '0;
         p_rd  <= '0;
         p_err <= '0;
         for (int i = 0; i < RD_LAT; i++) p_dat[i] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         p_vld <= flush ? '0 : RD_LAT'({p_vld, acc});
         p_rd  <= RD_LAT'({p_rd, acc & ~wb_we_i});
         p_err <= RD_LAT'({p_err, acc & bad});
         p_dat[0] <= (acc & ~wb_we_i & ~bad) ? mem[idx] : '0;
         for (int i = 1; i < RD_LAT; i++) p_dat[i] <= p_dat[i-1];
      end
   end

   // backing store is deliberately left out of reset
   always_ff @(posedge wb_clk_i) begin
      if (acc & wb_we_i & ~bad)
         for (int b = 0; b < BW; b++)
            if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
   end
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench; drivers queue expected responses, a negedge monitor pops and compares.
// Two instances: RD_LAT=2 for function/abort/reset, RD_LAT=8 for outstanding-limit stalls.
module tb_wb_mem_slave;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cyc [2], stb [2], we [2], ack [2], err [2], stall [2];
   logic [31:0] adr [2], dat_i [2], dat_o [2];
   logic [3:0]  sel [2];

   typedef struct {logic e; logic [31:0] d; int at;} exp_t;
   exp_t q0[$], q1[$];
   int errors = 0, checks = 0, cyc_n = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   wb_mem_slave #(.MEM_WORDS(1024), .RD_LAT(2), .MAX_OUTST(4)) dut (
      .wb_clk_i(clk), .rst_n(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
      .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_sel_i(sel[0]), .wb_dat_o(dat_o[0]),
      .wb_ack_o(ack[0]), .wb_stall_o(stall[0]), .wb_err_o(err[0]));

   wb_mem_slave #(.MEM_WORDS(1024), .RD_LAT(8), .MAX_OUTST(4)) dut8 (
      .wb_clk_i(clk), .rst_n(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
      .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_sel_i(sel[1]), .wb_dat_o(dat_o[1]),
      .wb_ack_o(ack[1]), .wb_stall_o(stall[1]), .wb_err_o(err[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int d);
      exp_t x;
      check($sformatf("ack_err_excl%0d", d), 32'(ack[d] & err[d]), 0);
      if (ack[d] | err[d]) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp%0d: got ack=%b err=%b expected none", d, ack[d], err[d]);
         end else begin
            if (d == 0) x = q0.pop_front();
            else x = q1.pop_front();
            check($sformatf("resp_err%0d", d), 32'(err[d]), 32'(x.e));
            check($sformatf("resp_data%0d", d), dat_o[d], x.d);
            check($sformatf("resp_edge%0d", d), cyc_n + 1, x.at);
         end
      end else check($sformatf("idle_data%0d", d), dat_o[d], 0);
   endtask

   always @(negedge clk) begin
      #2;
      mon(0);
      mon(1);
   end

   task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic push, input logic e, input logic [31:0] ed,
                        output int stalls);
      exp_t x;
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
      #1;
      stalls = 0;
      while (stall[d] && stalls < 50) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stall[d]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout%0d: got stall=1 expected accept", d);
      end else if (push) begin
         x.e = e; x.d = ed; x.at = cyc_n + 1 + (d == 0 ? 2 : 8);
         if (d == 0) q0.push_back(x);
         else q1.push_back(x);
      end
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
      int st;
      issue(d, 1'b1, a, wd, s, 1'b1, 1'b0, 32'h0, st);
   endtask

   task automatic rd(input int d, input logic [31:0] a, input logic [31:0] ed);
      int st;
      issue(d, 1'b0, a, 32'h0, 4'h0, 1'b1, 1'b0, ed, st);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      stb[d] = 1'b0;
      we[d] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      int st, first, tot;
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; dat_i[d] = 0; sel[d] = 0;
      end
      repeat (3) @(negedge clk);
      #1;
      check("rst_ack", 32'(ack[0]), 0);
      check("rst_err", 32'(err[0]), 0);
      check("rst_stall", 32'(stall[0]), 0);
      check("rst_dat", dat_o[0], 0);
      @(negedge clk) rst_n = 1'b1;

      wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
      rd(0, 32'h10, 32'hDEADBEEF);
      wr(0, 32'h10, 32'h11223344, 4'h3);
      rd(0, 32'h10, 32'hDEAD3344);
      wr(0, 32'h14, 32'h00000000, 4'hF);
      wr(0, 32'h14, 32'hAABBCCDD, 4'hA);
      rd(0, 32'h14, 32'hAA00CC00);
      wr(0, 32'h10, 32'h55667788, 4'h4);
      rd(0, 32'h10, 32'hDE663344);
      for (int i = 0; i < 8; i++) wr(0, 32'h40 + 4 * i, 32'hA0000000 + i, 4'hF);
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b0, 32'h40 + 4 * i, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0000000 + i, st);
         tot += st;
      end
      check("b2b_stalls", tot, 0);
      wr(0, 32'h0, 32'hCAFEF00D, 4'hF);
`ifdef WB_MEM_SLAVE_ADDR_ERR_EN
      issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, st);
      issue(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0, st);
      rd(0, 32'h0, 32'hCAFEF00D);
`else
      rd(0, 32'h1000, 32'hCAFEF00D);
`endif
      idle(0);
      drain();

      // abort: two reads accepted, then cycle dropped before any ack
      issue(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, st);
      issue(0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, st);
      @(negedge clk);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      #1 check("abort_pre_stall", 32'(stall[0]), 0);
      @(negedge clk);
      #1 check("abort_stall", 32'(stall[0]), 1);
      @(negedge clk);
      #1 check("abort_post_stall", 32'(stall[0]), 0);
      check("abort_state", 32'(dut.state), 0);
      check("abort_cnt", 32'(dut.cnt), 0);
      rd(0, 32'h10, 32'hDE663344);
      idle(0);
      drain();

      // reset mid-burst drops pending responses, memory survives
      issue(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, st);
      issue(0, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, st);
      @(negedge clk);
      rst_n = 1'b0; stb[0] = 1'b0;
      #1 check("midrst_ack", 32'(ack[0]), 0);
      check("midrst_stall", 32'(stall[0]), 0);
      @(negedge clk) rst_n = 1'b1;
      issue(0, 1'b0, 32'h48, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0000002, st);
      check("post_rst_accept", st, 0);
      idle(0);
      drain();

      // RD_LAT=8: outstanding limit throttles the fifth read, order preserved
      for (int i = 0; i < 8; i++) wr(1, 32'h40 + 4 * i, 32'hB0000000 + i, 4'hF);
      idle(1);
      drain();
      first = -1;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         issue(1, 1'b0, 32'h40 + 4 * i, 32'h0, 4'h0, 1'b1, 1'b0, 32'hB0000000 + i, st);
         if (st > 0 && first < 0) first = i;
         tot += st;
      end
      check("lat8_first_stall", first, 4);
      check("lat8_stalls", tot, 4);
      idle(1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
